// File: rtl/riscv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_pkg: immediate-format codes, packer error codes and packer FSM states.
// Rev 1.0
// ----------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_OVF   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PACK  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } packer_state_t;

endpackage
`default_nettype wire

// File: rtl/imm_pack.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imm_pack: combinational I/S/B/J scatter of an immediate plus range/alignment checks.
// Rev 1.0
// ----------------------------------------------------------------------------
module imm_pack
  import riscv_pkg::*;
(
  input  logic [1:0]  i_immsrc,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_range_err,
  output logic        o_align_err
);

  always_comb begin
    o_word      = 32'h0000_0000;
    o_range_err = 1'b0;
    o_align_err = 1'b0;
    case (i_immsrc)
      IMM_I: begin
        o_word      = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        o_range_err = (i_imm[31:11] != {21{i_imm[31]}});
      end
      IMM_S: begin
        o_word      = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        o_range_err = (i_imm[31:11] != {21{i_imm[31]}});
      end
      IMM_B: begin
        o_word      = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                       i_imm[4:1], i_imm[11], i_opcode};
        o_range_err = (i_imm[31:12] != {20{i_imm[31]}});
        o_align_err = i_imm[0];
      end
      default: begin
        // J: bit 0 of the byte offset is implied and must be zero
        o_word      = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        o_range_err = (i_imm[31:20] != {12{i_imm[31]}});
        o_align_err = i_imm[0];
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_packer: packs decoded fields into RV32 words and writes them to instruction memory.
// Rev 1.0
// ----------------------------------------------------------------------------
module instr_packer
  import riscv_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_immsrc,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] C_ONE   = (ADDR_W+1)'(1);

  packer_state_t r_state;
  logic [1:0]    r_immsrc;
  logic [6:0]    r_opcode;
  logic [4:0]    r_rd;
  logic [2:0]    r_funct3;
  logic [4:0]    r_rs1;
  logic [4:0]    r_rs2;
  logic [31:0]   r_imm;
  logic          r_last;
  logic [31:0]   r_word;

  logic [31:0]   w_word;
  logic          w_range_err;
  logic          w_align_err;

  imm_pack u_imm_pack (
    .i_immsrc    (r_immsrc),
    .i_opcode    (r_opcode),
    .i_rd        (r_rd),
    .i_funct3    (r_funct3),
    .i_rs1       (r_rs1),
    .i_rs2       (r_rs2),
    .i_imm       (r_imm),
    .o_word      (w_word),
    .o_range_err (w_range_err),
    .o_align_err (w_align_err)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= 32'h0000_0000;
      count    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      r_immsrc <= IMM_I;
      r_opcode <= 7'd0;
      r_rd     <= 5'd0;
      r_funct3 <= 3'd0;
      r_rs1    <= 5'd0;
      r_rs2    <= 5'd0;
      r_imm    <= 32'h0000_0000;
      r_last   <= 1'b0;
      r_word   <= 32'h0000_0000;
    end else begin
      wr_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // in_ready is held low for the first cycle out of reset
          if (!in_ready) begin
            in_ready <= 1'b1;
          end else if (in_valid) begin
            r_immsrc <= in_immsrc;
            r_opcode <= in_opcode;
            r_rd     <= in_rd;
            r_funct3 <= in_funct3;
            r_rs1    <= in_rs1;
            r_rs2    <= in_rs2;
            r_imm    <= in_imm;
            r_last   <= in_last;
            in_ready <= 1'b0;
            r_state  <= ST_PACK;
          end
        end
        ST_PACK: begin
          r_word <= w_word;
          if (count == C_DEPTH) begin
            err      <= 1'b1;
            err_code <= ERR_OVF;
            r_state  <= ST_ERROR;
          end else if (w_range_err) begin
            err      <= 1'b1;
            err_code <= ERR_RANGE;
            r_state  <= ST_ERROR;
          end else if (w_align_err) begin
            err      <= 1'b1;
            err_code <= ERR_ALIGN;
            r_state  <= ST_ERROR;
          end else begin
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          wr_en   <= 1'b1;
          wr_addr <= count[ADDR_W-1:0];
          wr_data <= r_word;
          count   <= count + C_ONE;
          if (r_last) begin
            done    <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            in_ready <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        ST_DONE, ST_ERROR: begin
          in_ready <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_instr_packer: vector table plus scoreboard bench for instr_packer.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_instr_packer;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst_n4, sel;
  logic        in_valid, in_last;
  logic [1:0]  in_immsrc;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;

  logic        a_ready, a_wr_en, a_done, a_err;
  logic [5:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic [6:0]  a_count;
  logic [1:0]  a_code;
  logic        b_ready, b_wr_en, b_done, b_err;
  logic [5:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic [6:0]  b_count;
  logic [1:0]  b_code;

  logic        m_ready, m_wr_en, m_done, m_err;
  logic [5:0]  m_wr_addr;
  logic [31:0] m_wr_data;
  logic [6:0]  m_count;
  logic [1:0]  m_code;
  assign m_ready   = sel ? b_ready   : a_ready;
  assign m_wr_en   = sel ? b_wr_en   : a_wr_en;
  assign m_done    = sel ? b_done    : a_done;
  assign m_err     = sel ? b_err     : a_err;
  assign m_wr_addr = sel ? b_wr_addr : a_wr_addr;
  assign m_wr_data = sel ? b_wr_data : a_wr_data;
  assign m_count   = sel ? b_count   : a_count;
  assign m_code    = sel ? b_code    : a_code;

  instr_packer #(.DEPTH(64), .ADDR_W(6)) u_dut (
    .clk(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(a_ready),
    .in_immsrc(in_immsrc), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .count(a_count),
    .done(a_done), .err(a_err), .err_code(a_code)
  );

  instr_packer #(.DEPTH(4), .ADDR_W(6)) u_dut4 (
    .clk(clk), .reset_n(rst_n4), .in_valid(in_valid), .in_ready(b_ready),
    .in_immsrc(in_immsrc), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .count(b_count),
    .done(b_done), .err(b_err), .err_code(b_code)
  );

  typedef struct {
    logic [1:0]  src;
    logic [6:0]  opc;
    logic [31:0] imm;
    logic        has_data;
    logic [31:0] data;
    logic [5:0]  addr;
  } exp_t;

  typedef struct {
    logic [1:0]  s;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        last;
    logic [31:0] data;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model of the core's immediate extender
  function automatic logic [31:0] ext(input logic [1:0] s, input logic [31:0] w);
    case (s)
      IMM_I:   return {{20{w[31]}}, w[31:20]};
      IMM_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
      IMM_B:   return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      default: return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (m_wr_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(m_wr_en), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(m_wr_addr), 32'(e.addr));
        if (e.has_data) begin
          chk("wr_data", m_wr_data, e.data);
        end else begin
          chk("roundtrip", ext(e.src, m_wr_data), e.imm);
          chk("opcode", 32'(m_wr_data[6:0]), 32'(e.opc));
        end
      end
    end
  end

  task automatic push(input logic [1:0] s, input logic [6:0] op, input logic [31:0] imm,
                      input logic hd, input logic [31:0] d, input logic [5:0] a);
    exp_t e;
    e.src = s; e.opc = op; e.imm = imm; e.has_data = hd; e.data = d; e.addr = a;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [1:0] s, input logic [6:0] op, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic last);
    int k;
    @(negedge clk);
    in_immsrc = s; in_opcode = op; in_rd = rd; in_funct3 = f3;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last; in_valid = 1'b1;
    k = 0;
    while (!m_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!m_ready) begin
      chk("ready_timeout", 32'(m_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_evt(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(m_wr_en || m_err) && lat < 12);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; rst_n4 = 1'b0;
    repeat (2) @(negedge clk);
    if (sel) rst_n4 = 1'b1;
    else     rst_n  = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    vec_t        tv[4];
    int          lat;
    int          k;
    logic [31:0] r, imm;
    logic [1:0]  s;

    tv[0] = '{IMM_I, 7'b0010011, 5'd5,  3'd0, 5'd0, 5'd17, 32'hFFFF_FFFF, 1'b0, 32'hFFF0_0293};
    tv[1] = '{IMM_S, 7'b0100011, 5'd31, 3'd2, 5'd2, 5'd6,  32'd8,         1'b0, 32'h0061_2423};
    tv[2] = '{IMM_B, 7'b1100011, 5'd9,  3'd0, 5'd0, 5'd0,  32'hFFFF_FFFC, 1'b0, 32'hFE00_0EE3};
    tv[3] = '{IMM_J, 7'b1101111, 5'd1,  3'd7, 5'd3, 5'd4,  32'h0000_0800, 1'b1, 32'h0010_00EF};

    sel = 1'b0; rst_n = 1'b0; rst_n4 = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_immsrc = 2'b00; in_opcode = 7'd0; in_rd = 5'd0; in_funct3 = 3'd0;
    in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(m_ready), 32'd0);
    chk("rst_wr_en",    32'(m_wr_en), 32'd0);
    chk("rst_wr_addr",  32'(m_wr_addr), 32'd0);
    chk("rst_wr_data",  m_wr_data, 32'd0);
    chk("rst_count",    32'(m_count), 32'd0);
    chk("rst_done",     32'(m_done), 32'd0);
    chk("rst_err",      32'(m_err), 32'd0);
    chk("rst_err_code", 32'(m_code), 32'd0);
    rst_n = 1'b1;

    // Test-plan program: I, S, B, J at addresses 0..3
    for (int i = 0; i < 4; i++) begin
      push(tv[i].s, tv[i].op, tv[i].imm, 1'b1, tv[i].data, 6'(i));
      drive(tv[i].s, tv[i].op, tv[i].rd, tv[i].f3, tv[i].rs1, tv[i].rs2, tv[i].imm, tv[i].last);
      wait_evt(lat);
      chk("latency", 32'(lat), 32'd3);
      chk("count", 32'(m_count), 32'(i + 1));
    end
    chk("done", 32'(m_done), 32'd1);
    in_valid = 1'b1;
    repeat (6) @(negedge clk);
    chk("done_in_ready", 32'(m_ready), 32'd0);
    chk("done_count", 32'(m_count), 32'd4);
    chk("done_err", 32'(m_err), 32'd0);
    in_valid = 1'b0;

    // Range boundaries for I, then a rejected last request
    reset_dut();
    push(IMM_I, 7'b0010011, 32'hFFFF_F800, 1'b1, 32'h8000_0013, 6'd0);
    drive(IMM_I, 7'b0010011, 5'd0, 3'd0, 5'd0, 5'd0, 32'hFFFF_F800, 1'b0);
    wait_evt(lat);
    push(IMM_I, 7'b0010011, 32'd2047, 1'b1, 32'h7FF0_0013, 6'd1);
    drive(IMM_I, 7'b0010011, 5'd0, 3'd0, 5'd0, 5'd0, 32'd2047, 1'b0);
    wait_evt(lat);
    drive(IMM_I, 7'b0010011, 5'd1, 3'd0, 5'd1, 5'd0, 32'd2048, 1'b1);
    wait_evt(lat);
    chk("err_latency", 32'(lat), 32'd2);
    chk("range_err", 32'(m_err), 32'd1);
    chk("range_code", 32'(m_code), 32'(ERR_RANGE));
    chk("reject_no_done", 32'(m_done), 32'd0);
    repeat (3) @(negedge clk);
    chk("err_in_ready", 32'(m_ready), 32'd0);
    chk("err_count", 32'(m_count), 32'd2);

    reset_dut();
    drive(IMM_B, 7'b1100011, 5'd0, 3'd0, 5'd0, 5'd0, 32'd3, 1'b0);
    wait_evt(lat);
    chk("align_code", 32'(m_code), 32'(ERR_ALIGN));

    // Range outranks misalignment
    reset_dut();
    drive(IMM_B, 7'b1100011, 5'd0, 3'd0, 5'd0, 5'd0, 32'h0000_1001, 1'b0);
    wait_evt(lat);
    chk("prio_code", 32'(m_code), 32'(ERR_RANGE));

    reset_dut();
    drive(IMM_J, 7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 32'h0010_0000, 1'b0);
    wait_evt(lat);
    chk("j_range_code", 32'(m_code), 32'(ERR_RANGE));

    // DEPTH=4 instance: four writes then overflow
    sel = 1'b1;
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      r   = $urandom;
      imm = {{20{r[11]}}, r[11:0]};
      if (i < 4) push(IMM_I, 7'b0000011, imm, 1'b0, 32'd0, 6'(i));
      drive(IMM_I, 7'b0000011, r[16:12], r[19:17], r[24:20], 5'd0, imm, 1'b0);
      wait_evt(lat);
    end
    chk("ovf_err", 32'(m_err), 32'd1);
    chk("ovf_code", 32'(m_code), 32'(ERR_OVF));
    chk("ovf_count", 32'(m_count), 32'd4);
    sel = 1'b0;

    // Reset while in PACK drops the pending write
    reset_dut();
    push(IMM_I, 7'b0010011, 32'd5, 1'b1, 32'h0050_0193, 6'd0);
    drive(IMM_I, 7'b0010011, 5'd3, 3'd0, 5'd0, 5'd0, 32'd5, 1'b0);
    wait_evt(lat);
    drive(IMM_I, 7'b0010011, 5'd4, 3'd0, 5'd0, 5'd0, 32'd7, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_wr_en", 32'(m_wr_en), 32'd0);
    chk("mid_count", 32'(m_count), 32'd0);
    chk("mid_wr_data", m_wr_data, 32'd0);
    chk("mid_wr_addr", 32'(m_wr_addr), 32'd0);
    chk("mid_err", {30'd0, m_err, m_done}, 32'd0);
    chk("mid_in_ready", 32'(m_ready), 32'd0);
    rst_n = 1'b1;
    k = 0;
    while (!m_ready && k < 5) begin
      @(negedge clk);
      k++;
    end
    chk("mid_ready_after", 32'(m_ready), 32'd1);

    // Reset while in WRITE
    drive(IMM_I, 7'b0010011, 5'd4, 3'd0, 5'd0, 5'd0, 32'd9, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("wr_reset_count", 32'(m_count), 32'd0);

    // Random legal requests must round-trip through the extender
    reset_dut();
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      s = 2'($urandom_range(0, 3));
      case (s)
        IMM_I, IMM_S: imm = {{20{r[11]}}, r[11:0]};
        IMM_B:        imm = {{19{r[12]}}, r[12:1], 1'b0};
        default:      imm = {{11{r[20]}}, r[20:1], 1'b0};
      endcase
      push(s, {r[31:27], 2'b11}, imm, 1'b0, 32'd0, 6'(i));
      drive(s, {r[31:27], 2'b11}, r[25:21], r[24:22], r[30:26], r[29:25], imm, 1'b0);
      wait_evt(lat);
      chk("rand_latency", 32'(lat), 32'd3);
    end
    chk("rand_count", 32'(m_count), 32'd40);
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
